// File: rtl/cic_decim_comb_pkg.sv
// Shared constants and helpers for the CIC comb/decimate back end.
// The bit-growth helper is shared with the integrator so both sides size DIN_WIDTH identically.
package cic_decim_comb_pkg;

  localparam int MAX_DIFF_DELAY = 2;

  // Register growth of a CIC filter: STAGES * log2(R*M).
  function automatic int cic_growth(input int stages, input int decimation, input int diff_delay);
    return stages * $clog2(decimation * diff_delay);
  endfunction

  function automatic bit diff_delay_ok(input int diff_delay);
    return (diff_delay >= 1) && (diff_delay <= MAX_DIFF_DELAY);
  endfunction

  function automatic int cnt_width(input int decimation);
    return (decimation > 1) ? $clog2(decimation) : 1;
  endfunction

endpackage

// File: rtl/cic_decim_comb_if.sv
// Sample stream into and decimated stream out of the comb back end.
interface cic_decim_comb_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32
);
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         din_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_valid;

  modport master (output din, output din_valid, input dout, input dout_valid);
  modport slave  (input din, input din_valid, output dout, output dout_valid);
endinterface

// File: rtl/cic_decim_comb_comb_stage.sv
// One comb section y[n] = x[n] - x[n-DIFF_DELAY], advancing only on a valid pulse.
module comb_stage #(
  parameter int WIDTH      = 32,
  parameter int DIFF_DELAY = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout,
  output logic                    dout_valid
);

  logic signed [WIDTH-1:0] dl_q [DIFF_DELAY];
  logic signed [WIDTH-1:0] data_p1_q;
  logic signed [WIDTH-1:0] data_p1_d;
  logic                    vld_p1_q;

  // Same-width subtraction: wraps modulo 2^WIDTH as CIC arithmetic requires.
  always_comb begin
    data_p1_d = din - dl_q[DIFF_DELAY-1];
  end

  // ---- stage boundary: comb output register ----
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      for (int i = 0; i < DIFF_DELAY; i++) dl_q[i] <= '0;
    end else begin
      vld_p1_q <= din_valid;
      if (din_valid) begin
        data_p1_q <= data_p1_d;
        dl_q[0]   <= din;
        for (int i = 1; i < DIFF_DELAY; i++) dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign dout       = data_p1_q;
  assign dout_valid = vld_p1_q;

endmodule

// File: rtl/cic_decim_comb.sv
// CIC back end: keeps one of every DECIMATION valid samples and runs it through STAGES
// pipelined comb sections; dout is the top DOUT_WIDTH bits of the last comb.
module cic_decim_comb
  import cic_decim_comb_pkg::*;
#(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int STAGES     = 3,
  parameter int DECIMATION = 8,
  parameter int DIFF_DELAY = 1
) (
  input logic              clk_in,
  input logic              rst_n,
  cic_decim_comb_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(DECIMATION);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIMATION - 1);

  if (!diff_delay_ok(DIFF_DELAY)) begin : g_bad_diff_delay
    $error("cic_decim_comb: DIFF_DELAY must be 1 or 2");
  end
  if (DOUT_WIDTH > DIN_WIDTH) begin : g_bad_dout_width
    $error("cic_decim_comb: DOUT_WIDTH must not exceed DIN_WIDTH");
  end
  if (STAGES < 1 || DECIMATION < 1) begin : g_bad_stages
    $error("cic_decim_comb: STAGES and DECIMATION must be at least 1");
  end

  function automatic logic signed [DOUT_WIDTH-1:0] trunc_out(input logic signed [DIN_WIDTH-1:0] x);
    return x[DIN_WIDTH-1 -: DOUT_WIDTH];
  endfunction

  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        dec_stb;
  logic signed [DIN_WIDTH-1:0] data_p0_q;
  logic                        vld_p0_q;

  always_comb begin
    cnt_d   = cnt_q;
    dec_stb = 1'b0;
    if (bus.din_valid) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        dec_stb = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---- stage boundary: decimator / sample capture ----
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      vld_p0_q <= dec_stb;
      if (dec_stb) data_p0_q <= bus.din;
    end
  end

  logic signed [DIN_WIDTH-1:0] stg_data [STAGES+1];
  logic                        stg_vld  [STAGES+1];

  assign stg_data[0] = data_p0_q;
  assign stg_vld[0]  = vld_p0_q;

  // ---- stage boundaries: one per comb section ----
  for (genvar k = 1; k <= STAGES; k++) begin : g_comb
    comb_stage #(
      .WIDTH      (DIN_WIDTH),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_comb (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .din        (stg_data[k-1]),
      .din_valid  (stg_vld[k-1]),
      .dout       (stg_data[k]),
      .dout_valid (stg_vld[k])
    );
  end

  assign bus.dout       = trunc_out(stg_data[STAGES]);
  assign bus.dout_valid = stg_vld[STAGES];

endmodule

// File: tb/tb_cic_decim_comb.sv
// Five differently parameterised instances driven side by side; a history-based comb model
// predicts every strobe time and value, plus directed checks of the classic CIC sequences.
module tb_cic_decim_comb;

  localparam int N = 5;

  int W_  [N] = '{32, 32, 8, 32, 24};
  int OW_ [N] = '{32, 32, 8, 32, 12};
  int S_  [N] = '{3,  1,  1, 3,  2};
  int R_  [N] = '{1,  4,  1, 4,  3};
  int M_  [N] = '{1,  1,  1, 1,  2};

  logic clk;
  logic [N-1:0] rstn;
  logic [N-1:0] vin;
  longint       din_v [N];
  logic [31:0]  od [N];
  logic [N-1:0] ov;

  cic_decim_comb_if #(.DIN_WIDTH(32), .DOUT_WIDTH(32)) ifa ();
  cic_decim_comb_if #(.DIN_WIDTH(32), .DOUT_WIDTH(32)) ifb ();
  cic_decim_comb_if #(.DIN_WIDTH(8),  .DOUT_WIDTH(8))  ifc ();
  cic_decim_comb_if #(.DIN_WIDTH(32), .DOUT_WIDTH(32)) ifd ();
  cic_decim_comb_if #(.DIN_WIDTH(24), .DOUT_WIDTH(12)) ife ();

  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(32), .STAGES(3), .DECIMATION(1), .DIFF_DELAY(1))
    u_a (.clk_in(clk), .rst_n(rstn[0]), .bus(ifa));
  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(32), .STAGES(1), .DECIMATION(4), .DIFF_DELAY(1))
    u_b (.clk_in(clk), .rst_n(rstn[1]), .bus(ifb));
  cic_decim_comb #(.DIN_WIDTH(8), .DOUT_WIDTH(8), .STAGES(1), .DECIMATION(1), .DIFF_DELAY(1))
    u_c (.clk_in(clk), .rst_n(rstn[2]), .bus(ifc));
  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(32), .STAGES(3), .DECIMATION(4), .DIFF_DELAY(1))
    u_d (.clk_in(clk), .rst_n(rstn[3]), .bus(ifd));
  cic_decim_comb #(.DIN_WIDTH(24), .DOUT_WIDTH(12), .STAGES(2), .DECIMATION(3), .DIFF_DELAY(2))
    u_e (.clk_in(clk), .rst_n(rstn[4]), .bus(ife));

  assign ifa.din = din_v[0][31:0];  assign ifa.din_valid = vin[0];
  assign ifb.din = din_v[1][31:0];  assign ifb.din_valid = vin[1];
  assign ifc.din = din_v[2][7:0];   assign ifc.din_valid = vin[2];
  assign ifd.din = din_v[3][31:0];  assign ifd.din_valid = vin[3];
  assign ife.din = din_v[4][23:0];  assign ife.din_valid = vin[4];

  assign od[0] = ifa.dout;            assign ov[0] = ifa.dout_valid;
  assign od[1] = ifb.dout;            assign ov[1] = ifb.dout_valid;
  assign od[2] = {24'b0, ifc.dout};   assign ov[2] = ifc.dout_valid;
  assign od[3] = ifd.dout;            assign ov[3] = ifd.dout_valid;
  assign od[4] = {20'b0, ife.dout};   assign ov[4] = ife.dout_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int     cnt  [N];
  longint kept [N][$];
  int     et   [N][$];
  longint ev   [N][$];
  longint held [N];
  longint got  [N][$];
  int     gt   [N][$];
  longint i1, i2, i3;

  function automatic longint msk(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  // Comb every accepted sample since reset, S times over, and keep the newest result.
  function automatic longint model_out(input int d);
    longint v[$];
    longint m;
    m = msk(W_[d]);
    v = kept[d];
    for (int s = 0; s < S_[d]; s++)
      for (int j = v.size() - 1; j >= 0; j--)
        v[j] = (v[j] - ((j >= M_[d]) ? v[j - M_[d]] : longint'(0))) & m;
    return (v[v.size() - 1] >> (W_[d] - OW_[d])) & msk(OW_[d]);
  endfunction

  function automatic logic [63:0] gq(input int d, input int i);
    return (i < got[d].size()) ? 64'(got[d][i]) : 64'bx;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < N; d++) begin
      if (!rstn[d]) begin
        cnt[d] = 0; held[d] = 0;
        kept[d].delete(); et[d].delete(); ev[d].delete();
      end else if (vin[d]) begin
        if (cnt[d] == R_[d] - 1) begin
          cnt[d] = 0;
          kept[d].push_back(din_v[d] & msk(W_[d]));
          et[d].push_back(cyc + S_[d]);
          ev[d].push_back(model_out(d));
        end else begin
          cnt[d]++;
        end
      end
    end
    #1;
    for (int d = 0; d < N; d++) begin
      bit exp_v;
      exp_v = (et[d].size() > 0) && (et[d][0] == cyc);
      if (exp_v) begin
        held[d] = ev[d].pop_front();
        void'(et[d].pop_front());
      end
      chk($sformatf("valid_dut%0d_cyc%0d", d, cyc), 64'(ov[d]), 64'(exp_v));
      chk($sformatf("dout_dut%0d_cyc%0d", d, cyc), 64'(od[d]), 64'(held[d]));
      if (ov[d] === 1'b1) begin
        got[d].push_back(longint'(od[d]));
        gt[d].push_back(cyc);
      end
    end
    // Background streams: integrator chain into D, random samples with one reset into E.
    i1 = (i1 + 1) & msk(32);
    i2 = (i2 + i1) & msk(32);
    i3 = (i3 + i2) & msk(32);
    vin[3]   = 1'b1;
    din_v[3] = i3;
    vin[4]   = ($urandom_range(0, 9) < 7);
    din_v[4] = longint'($urandom) & msk(24);
    rstn[4]  = !(cyc < 3 || (cyc >= 150 && cyc < 152));
  endtask

  initial begin
    int acc0, e, n;
    longint bramp;
    rstn = '0; vin = '0;
    for (int d = 0; d < N; d++) begin din_v[d] = 0; cnt[d] = 0; held[d] = 0; end
    i1 = 0; i2 = 0; i3 = 0;
    repeat (3) tick();

    // Step on A, ramp on B, wrap pair on C.
    rstn[3:0] = '1;
    acc0 = cyc + 1;
    for (int c = 0; c < 40; c++) begin
      vin[0] = 1'b1; din_v[0] = 5;
      vin[1] = 1'b1; din_v[1] = c;
      vin[2] = (c < 2); din_v[2] = (c == 0) ? 127 : ((-128) & msk(8));
      tick();
    end
    chk("a_step0", gq(0, 0), 5);
    chk("a_step1", gq(0, 1), (-10) & msk(32));
    chk("a_step2", gq(0, 2), 5);
    chk("a_step3", gq(0, 3), 0);
    chk("a_latency_cycles", 64'(gt[0].size() > 0 ? gt[0][0] - acc0 + 1 : -1), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b_dec%0d", i), gq(1, i), (i == 0) ? 3 : 4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b_period%0d", i), 64'(gt[1].size() > i + 1 ? gt[1][i+1] - gt[1][i] : -1), 4);
    chk("c_wrap0", gq(2, 0), 127);
    chk("c_wrap1", gq(2, 1), 1);

    // A: one sample then reset two cycles later; B: reset before gapped ramp.
    for (int d = 0; d < 3; d++) begin got[d].delete(); gt[d].delete(); end
    vin[0] = 1'b1; din_v[0] = 9; rstn[1] = 1'b0; vin[1] = 1'b0; vin[2] = 1'b0;
    tick();
    e = cyc;
    vin[0] = 1'b0; rstn[1] = 1'b1;
    tick();
    rstn[0] = 1'b0;
    tick(); tick();
    rstn[0] = 1'b1;
    repeat (4) tick();
    n = 0;
    foreach (gt[0][i]) if (gt[0][i] >= e + 2) n++;
    chk("a_no_strobe_after_reset", 64'(n), 0);
    chk("a_dout_zero_after_reset", 64'(od[0]), 0);

    got[0].delete(); got[1].delete(); gt[1].delete();
    bramp = 0;
    for (int c = 0; c < 40; c++) begin
      vin[0] = 1'b1; din_v[0] = 5;
      vin[1] = (c % 2 == 0); din_v[1] = bramp;
      tick();
      if (c % 2 == 0) bramp++;
    end
    chk("a_restart0", gq(0, 0), 5);
    chk("a_restart1", gq(0, 1), (-10) & msk(32));
    chk("a_restart2", gq(0, 2), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("b_gap%0d", i), gq(1, i), (i == 0) ? 3 : 4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b_gap_period%0d", i), 64'(gt[1].size() > i + 1 ? gt[1][i+1] - gt[1][i] : -1), 8);

    // Let the random stream on E and the integrator-fed D run on.
    vin[0] = 1'b0; vin[1] = 1'b0;
    repeat (250) tick();
    n = got[3].size();
    for (int i = 1; i <= 3; i++) chk($sformatf("d_e2e_tail%0d", i), gq(3, n - i), 64);
    chk("e_strobe_count_nonzero", 64'(got[4].size() > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
